// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 operator-slot sequencer.
package opl3_pkg;

  localparam int NUM_BANKS              = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int NUM_OPS_TOTAL          = NUM_BANKS * NUM_OPERATORS_PER_BANK;
  localparam int OP_NUM_WIDTH           = $clog2(NUM_OPERATORS_PER_BANK);

  localparam int CLK_DIV_COUNT = 494;
  localparam int CYCLES_PER_OP = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

endpackage

// File: rtl/opl3_op_sequencer_if.sv
// Host write bus of the sequencer: request/ready handshake in, gated register-file write out.
interface opl3_op_sequencer_if;
  import opl3_pkg::*;

  opl3_reg_wr_t wr_in;
  logic         wr_ready;
  opl3_reg_wr_t reg_wr;

  modport master (
    output wr_in,
    input  wr_ready,
    input  reg_wr
  );

  modport slave (
    input  wr_in,
    output wr_ready,
    output reg_wr
  );

endinterface

// File: rtl/opl3_sample_clk_div.sv
// Free-running sample-rate divider: one registered enable pulse every DIV_COUNT clocks.
module opl3_sample_clk_div
  import opl3_pkg::*;
#(
  parameter int DIV_COUNT = CLK_DIV_COUNT
) (
  input  logic clk,
  input  logic ic_n,
  output logic sample_clk_en_o
);

  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             sampleClkEn_q, sampleClkEn_d;

  // The enable is registered from the next count so it lines up with div_cnt == last.
  always_comb begin
    divCnt_d      = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
    sampleClkEn_d = (divCnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      divCnt_q      <= '0;
      sampleClkEn_q <= 1'b0;
    end else begin
      divCnt_q      <= divCnt_d;
      sampleClkEn_q <= sampleClkEn_d;
    end
  end

  assign sample_clk_en_o = sampleClkEn_q;

endmodule

// File: rtl/opl3_op_sequencer.sv
// Steps 36 operator slots once per sample period and buffers one host register write.
// Define OPL3_SEQ_WR_GATE_EN to hold buffered writes until the sequencer is idle.
module opl3_op_sequencer #(
  parameter int CLK_DIV_COUNT = opl3_pkg::CLK_DIV_COUNT,
  parameter int CYCLES_PER_OP = opl3_pkg::CYCLES_PER_OP
) (
  input  logic                              clk,
  input  logic                              ic_n,
  opl3_op_sequencer_if.slave                wr_bus,
  output logic                              sample_clk_en,
  output logic                              op_valid,
  output logic                              bank_num,
  output logic [opl3_pkg::OP_NUM_WIDTH-1:0] op_num,
  output logic                              sample_done
);
  import opl3_pkg::*;

  localparam int CYC_W = (CYCLES_PER_OP > 1) ? $clog2(CYCLES_PER_OP) : 1;
  localparam logic [CYC_W-1:0]        CYC_LAST = CYC_W'(CYCLES_PER_OP - 1);
  localparam logic [OP_NUM_WIDTH-1:0] OP_LAST  = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);

  // The whole slot sequence plus the return to IDLE must fit inside one sample period.
  if (NUM_OPS_TOTAL * CYCLES_PER_OP + 2 > CLK_DIV_COUNT) begin : g_bad_cfg
    $error("opl3_op_sequencer: CLK_DIV_COUNT too small for 36 slots of CYCLES_PER_OP");
  end

  seq_state_t              state_q, state_d;
  logic [CYC_W-1:0]        cycCnt_q, cycCnt_d;
  logic                    bank_q, bank_d;
  logic [OP_NUM_WIDTH-1:0] opNum_q, opNum_d;
  logic                    sampleDone_q, sampleDone_d;
  logic                    bufFull_q, bufFull_d;
  logic                    wrReady_q, wrReady_d;
  opl3_reg_wr_t            wrBuf_q, wrBuf_d;
  logic                    wrAccept;
  logic                    wrDrain;

  opl3_sample_clk_div #(
    .DIV_COUNT(CLK_DIV_COUNT)
  ) u_clk_div (
    .clk            (clk),
    .ic_n           (ic_n),
    .sample_clk_en_o(sample_clk_en)
  );

  always_comb begin
    state_d      = state_q;
    cycCnt_d     = cycCnt_q;
    bank_d       = bank_q;
    opNum_d      = opNum_q;
    sampleDone_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_clk_en) state_d = RUN;
      end
      RUN: begin
        if (cycCnt_q == CYC_LAST) begin
          cycCnt_d = '0;
          if (opNum_q == OP_LAST) begin
            opNum_d = '0;
            if (bank_q) begin
              state_d      = IDLE;
              bank_d       = 1'b0;
              sampleDone_d = 1'b1;
            end else begin
              bank_d = 1'b1;
            end
          end else begin
            opNum_d = opNum_q + OP_NUM_WIDTH'(1);
          end
        end else begin
          cycCnt_d = cycCnt_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept and drain never coincide: ready is low whenever the buffer holds a write.
  always_comb begin
    wrAccept = wr_bus.wr_in.valid && wrReady_q;
`ifdef OPL3_SEQ_WR_GATE_EN
    wrDrain  = bufFull_q && (state_q == IDLE) && !sample_clk_en;
`else
    wrDrain  = bufFull_q;
`endif
    bufFull_d = bufFull_q;
    wrBuf_d   = wrBuf_q;
    if (wrDrain) bufFull_d = 1'b0;
    if (wrAccept) begin
      bufFull_d = 1'b1;
      wrBuf_d   = wr_bus.wr_in;
    end
    wrReady_d = !bufFull_d;
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q      <= IDLE;
      cycCnt_q     <= '0;
      bank_q       <= 1'b0;
      opNum_q      <= '0;
      sampleDone_q <= 1'b0;
      bufFull_q    <= 1'b0;
      wrReady_q    <= 1'b0;
      wrBuf_q      <= '0;
    end else begin
      state_q      <= state_d;
      cycCnt_q     <= cycCnt_d;
      bank_q       <= bank_d;
      opNum_q      <= opNum_d;
      sampleDone_q <= sampleDone_d;
      bufFull_q    <= bufFull_d;
      wrReady_q    <= wrReady_d;
      wrBuf_q      <= wrBuf_d;
    end
  end

  always_comb begin
    op_valid        = (state_q == RUN) && (cycCnt_q == '0);
    bank_num        = bank_q;
    op_num          = opNum_q;
    sample_done     = sampleDone_q;
    wr_bus.wr_ready = wrReady_q;
    wr_bus.reg_wr   = wrDrain ? wrBuf_q : '0;
  end

endmodule
